// File: rtl/drink_reminder.sv
// Drink reminder: times the interval since the last drink of a debounced water level and drives
// reminder/empty indicators. Define DRINK_REMINDER_SNOOZE_EN to let snooze defer an active reminder.
module drink_reminder #(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned REMIND_TICKS = 1800,
  parameter int unsigned DRINK_DELTA  = 1,
  parameter int unsigned EMPTY_LEVEL  = 0,
  parameter int unsigned SNOOZE_TICKS = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] water_level,
  input  logic       snooze,
  output logic       remind_led,
  output logic       buzzer,
  output logic       empty_led,
  output logic       drink_pulse,
  output logic [7:0] drink_count
);

  localparam int unsigned PreW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TimerW = $clog2(REMIND_TICKS + 1);
  localparam logic [4:0]  DeltaW = 5'(DRINK_DELTA);
  localparam logic [4:0]  EmptyW = 5'(EMPTY_LEVEL);

  typedef enum logic [1:0] {StInit, StWait, StRemind, StEmpty} state_e;

  state_e            state;
  logic [PreW-1:0]   presc;
  logic [TimerW-1:0] timer;
  logic [3:0]        last_level;
  logic              tick, drink, refill, empty;

  assign tick   = (presc == PreW'(TICK_DIV - 1));
  // 5-bit compares so level + delta cannot wrap past 15
  assign drink  = ({1'b0, water_level} + DeltaW) <= {1'b0, last_level};
  assign refill = water_level > last_level;
  assign empty  = {1'b0, water_level} <= EmptyW;

`ifdef DRINK_REMINDER_SNOOZE_EN
  localparam logic [TimerW-1:0] SnoozeLoad = TimerW'(REMIND_TICKS - SNOOZE_TICKS);
`else
  logic unused_snooze;
  assign unused_snooze = snooze ^ (SNOOZE_TICKS > REMIND_TICKS);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StInit;
      presc       <= '0;
      timer       <= '0;
      last_level  <= '0;
      remind_led  <= 1'b0;
      buzzer      <= 1'b0;
      empty_led   <= 1'b0;
      drink_pulse <= 1'b0;
      drink_count <= '0;
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      drink_pulse <= 1'b0;
      unique case (state)
        StInit: begin
          last_level <= water_level;
          timer      <= '0;
          state      <= StWait;
        end
        StWait, StRemind: begin
          if (drink) begin
            drink_pulse <= 1'b1;
            if (drink_count != 8'hFF) drink_count <= drink_count + 8'd1;
            last_level <= water_level;
            timer      <= '0;
            remind_led <= 1'b0;
            buzzer     <= 1'b0;
            if (empty) begin
              state     <= StEmpty;
              empty_led <= 1'b1;
            end else begin
              state <= StWait;
            end
          end else if (empty) begin
            state      <= StEmpty;
            empty_led  <= 1'b1;
            remind_led <= 1'b0;
            buzzer     <= 1'b0;
            timer      <= '0;
`ifdef DRINK_REMINDER_SNOOZE_EN
          end else if (state == StRemind && snooze) begin
            state      <= StWait;
            timer      <= SnoozeLoad;
            remind_led <= 1'b0;
            buzzer     <= 1'b0;
`endif
          end else begin
            if (refill) last_level <= water_level;
            if (state == StWait && tick) begin
              if (timer == TimerW'(REMIND_TICKS - 1)) begin
                state      <= StRemind;
                remind_led <= 1'b1;
                buzzer     <= 1'b1;
              end else begin
                timer <= timer + 1'b1;
              end
            end else if (state == StRemind && tick) begin
              buzzer <= ~buzzer;
            end
          end
        end
        StEmpty: begin
          timer <= '0;
          // Leaving empty is a refill: resync the reference level, never count a drink
          if (!empty) begin
            last_level <= water_level;
            empty_led  <= 1'b0;
            state      <= StWait;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drink_reminder.sv
// Directed bench for drink_reminder with TICK_DIV=4, REMIND_TICKS=5, SNOOZE_TICKS=2.
module tb_drink_reminder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] water_level;
  logic       snooze;
  logic       remind_led, buzzer, empty_led, drink_pulse;
  logic [7:0] drink_count;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

`ifdef DRINK_REMINDER_SNOOZE_EN
  localparam logic SnzRemind = 1'b0;
`else
  localparam logic SnzRemind = 1'b1;
`endif

  drink_reminder #(
    .TICK_DIV    (4),
    .REMIND_TICKS(5),
    .DRINK_DELTA (1),
    .EMPTY_LEVEL (0),
    .SNOOZE_TICKS(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .water_level(water_level),
    .snooze     (snooze),
    .remind_led (remind_led),
    .buzzer     (buzzer),
    .empty_led  (empty_led),
    .drink_pulse(drink_pulse),
    .drink_count(drink_count)
  );

  always #5 clk = ~clk;

  // Edge number since reset release; prescaler ticks land on multiples of 4
  always @(posedge clk) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic to_edge(input int k);
    repeat (k - edges) @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    water_level = 4'd8;
    snooze      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_remind", remind_led, 1'b0);
    check1("rst_buzzer", buzzer, 1'b0);
    check1("rst_empty", empty_led, 1'b0);
    check1("rst_pulse", drink_pulse, 1'b0);
    check8("rst_count", drink_count, 8'd0);
    reset = 1'b0;

    // First reminder after the 5th tick (edge 20); buzzer toggles each tick
    to_edge(19); check1("remind_before", remind_led, 1'b0);
    to_edge(20); check1("remind_rise", remind_led, 1'b1);
    check1("buzz_entry", buzzer, 1'b1);
    to_edge(23); check1("buzz_hold", buzzer, 1'b1);
    to_edge(24); check1("buzz_toggle", buzzer, 1'b0);
    check8("count_idle", drink_count, 8'd0);

    // Drink in REMIND
    water_level = 4'd7;
    to_edge(25);
    check1("rem_drink_pulse", drink_pulse, 1'b1);
    check1("rem_drink_led", remind_led, 1'b0);
    check1("rem_drink_buzz", buzzer, 1'b0);
    check8("rem_drink_count", drink_count, 8'd1);
    to_edge(26); check1("pulse_one_cycle", drink_pulse, 1'b0);
    to_edge(43); check1("re_remind_before", remind_led, 1'b0);
    to_edge(44); check1("re_remind_rise", remind_led, 1'b1);

    // Reset in the middle of REMIND
    water_level = 4'd8;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check1("mid_rst_remind", remind_led, 1'b0);
    check1("mid_rst_buzzer", buzzer, 1'b0);
    check8("mid_rst_count", drink_count, 8'd0);
    reset = 1'b0;

    // Drink in WAIT after 3 ticks restarts the timer
    to_edge(12); water_level = 4'd7;
    to_edge(13);
    check1("wait_drink_pulse", drink_pulse, 1'b1);
    check8("wait_drink_count", drink_count, 8'd1);
    to_edge(14); check1("wait_pulse_drop", drink_pulse, 1'b0);
    // Refill after a tick must not clear the timer
    to_edge(17); water_level = 4'd8;
    to_edge(18);
    check1("refill_no_pulse", drink_pulse, 1'b0);
    check8("refill_count", drink_count, 8'd1);
    to_edge(31); check1("refill_remind_before", remind_led, 1'b0);
    to_edge(32); check1("refill_remind_rise", remind_led, 1'b1);
    // 8->7 only counts if the refill updated last_level
    water_level = 4'd7;
    to_edge(33);
    check1("post_refill_pulse", drink_pulse, 1'b1);
    check8("post_refill_count", drink_count, 8'd2);
    check1("post_refill_led", remind_led, 1'b0);

    // Drink on the expiry tick wins
    to_edge(51); check1("expiry_before", remind_led, 1'b0);
    water_level = 4'd6;
    to_edge(52);
    check1("expiry_drink_led", remind_led, 1'b0);
    check1("expiry_drink_pulse", drink_pulse, 1'b1);
    check8("expiry_drink_count", drink_count, 8'd3);
    to_edge(71); check1("expiry_next_before", remind_led, 1'b0);
    to_edge(72); check1("expiry_next_rise", remind_led, 1'b1);

    // Snooze
    snooze = 1'b1;
    to_edge(73); snooze = 1'b0;
    check1("snooze_led", remind_led, SnzRemind);
    to_edge(79); check1("snooze_before", remind_led, SnzRemind);
    to_edge(80); check1("snooze_rise", remind_led, 1'b1);

    // Drink and snooze together: drink, timer restarts from 0
    water_level = 4'd5;
    snooze = 1'b1;
    to_edge(81); snooze = 1'b0;
    check1("drk_snz_pulse", drink_pulse, 1'b1);
    check8("drk_snz_count", drink_count, 8'd4);
    check1("drk_snz_led", remind_led, 1'b0);
    to_edge(99);  check1("drk_snz_before", remind_led, 1'b0);
    to_edge(100); check1("drk_snz_rise", remind_led, 1'b1);

    // Drink to empty
    water_level = 4'd0;
    to_edge(101);
    check1("empty_pulse", drink_pulse, 1'b1);
    check8("empty_count", drink_count, 8'd5);
    check1("empty_led_on", empty_led, 1'b1);
    check1("empty_remind", remind_led, 1'b0);
    check1("empty_buzz", buzzer, 1'b0);
    to_edge(121);
    check1("empty_hold_led", empty_led, 1'b1);
    check1("empty_hold_buzz", buzzer, 1'b0);
    check1("empty_hold_remind", remind_led, 1'b0);
    check1("empty_hold_pulse", drink_pulse, 1'b0);
    water_level = 4'd15;
    to_edge(122);
    check1("refill_empty_led", empty_led, 1'b0);
    check1("refill_empty_pulse", drink_pulse, 1'b0);
    check8("refill_empty_count", drink_count, 8'd5);
    to_edge(139); check1("after_empty_before", remind_led, 1'b0);
    to_edge(140); check1("after_empty_rise", remind_led, 1'b1);

    // 260 drinks with refills: counter saturates, pulse keeps firing
    for (int i = 0; i < 260; i++) begin
      int exp_cnt;
      exp_cnt = (6 + i > 255) ? 255 : 6 + i;
      water_level = 4'd14;
      to_edge(edges + 1);
      check1("sat_pulse", drink_pulse, 1'b1);
      check8("sat_count", drink_count, 8'(exp_cnt));
      water_level = 4'd15;
      to_edge(edges + 1);
      check1("sat_refill_pulse", drink_pulse, 1'b0);
    end
    check8("sat_final", drink_count, 8'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
